// File: rtl/video_switch_ctrl.sv
// Source-switch controller for a 4:1 video stream mux. It waits for the end of the current
// frame, flips the select, then drops mux output until the new source presents its SOF beat.
module video_switch_ctrl #(
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned TIMEOUT  = 5000000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        req_valid,
  input  logic [1:0]  req_sel,
  output logic        req_ready,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic        mon_tuser,
  input  logic        mon_tlast,
  output logic [31:0] switch,
  output logic        drop,
  output logic        busy,
  output logic        switch_done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StRun, StDrain, StAlign} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cur_sel_q, cur_sel_d;
  logic [1:0]  pend_q, pend_d;
  logic [31:0] line_q, line_d;
  logic [31:0] timer_q, timer_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        hs, sof, frame_end, timer_hit;
  logic [31:0] eff_line, timer_inc;

  always_comb begin
    hs        = mon_tvalid && mon_tready;
    sof       = hs && mon_tuser;
    eff_line  = mon_tuser ? '0 : line_q;
    frame_end = hs && mon_tlast && (eff_line == 32'(V_ACTIVE - 1));
    timer_inc = timer_q + 32'd1;
    timer_hit = (timer_inc == 32'(TIMEOUT));
  end

  // Line position is tracked in every state so a drain starts from a known line.
  always_comb begin
    line_d = line_q;
    if (hs && mon_tlast) begin
      line_d = frame_end ? '0 : eff_line + 32'd1;
    end else if (sof) begin
      line_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    pend_d    = pend_q;
    timer_d   = timer_q;
    err_d     = err_q;
    done_d    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (req_valid && (req_sel != cur_sel_q)) begin
          pend_d  = req_sel;
          timer_d = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        timer_d = timer_inc;
        // A frame end coinciding with the timeout counts as a clean frame end.
        if (frame_end || timer_hit) begin
          err_d     = err_q || !frame_end;
          cur_sel_d = pend_q;
          timer_d   = '0;
          state_d   = StAlign;
        end
      end
      StAlign: begin
        timer_d = timer_inc;
        if (sof || timer_hit) begin
          err_d   = err_q || !sof;
          timer_d = '0;
          done_d  = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    busy_d = (state_d != StRun);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q   <= StRun;
      cur_sel_q <= 2'd0;
      pend_q    <= 2'd0;
      line_q    <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      pend_q    <= pend_d;
      line_q    <= line_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign req_ready   = (state_q == StRun);
  assign switch      = {30'd0, cur_sel_q};
  // SOF beat of the new source passes through; everything else in ALIGN is discarded.
  assign drop        = (state_q == StAlign) && !(mon_tvalid && mon_tuser);
  assign busy        = busy_q;
  assign switch_done = done_q;
  assign timeout_err = err_q;

endmodule

// File: doc/video_switch_ctrl.md
VIDEO_SWITCH_CTRL -- requirements
Module: video_switch_ctrl

Interface
REQ-001 SHALL provide parameter V_ACTIVE, default 1080: active lines per frame (minimum 1).
REQ-002 SHALL provide parameter TIMEOUT, default 5000000: maximum clk cycles allowed in DRAIN or ALIGN (minimum 1).
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  source-change request strobe.
- req_sel  in  2  requested source index 0..3.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- mon_tvalid, mon_tready, mon_tuser, mon_tlast  in  1 each  tap of the 4:1 mux output stream.
- switch  out  32  select word to the mux; bits 31:2 always 0.
- drop  out  1  glue forces mux-side tready=1 and downstream tvalid=0 while high.
- busy  out  1  high in any state other than RUN.
- switch_done  out  1  one-cycle pulse on return to RUN after a switch.
- timeout_err  out  1  sticky; set on any timeout.
REQ-004 SHALL treat a beat as a handshake only when mon_tvalid&&mon_tready.

Function
REQ-005 SHALL implement states RUN, DRAIN, ALIGN.
REQ-006 SHALL keep line_cnt at all times:
- handshake with mon_tuser: line_cnt treated as 0 for that beat.
- handshake with mon_tlast: line_cnt increments; on the frame-end beat it loads 0.
- tuser and tlast on the same beat: beat is line 0.
REQ-007 SHALL define frame_end as a handshake with mon_tlast=1 while the effective line index equals V_ACTIVE-1.
REQ-008 RUN: req_ready=1 and switch=cur_sel.
- Accepted request with req_sel!=cur_sel: latch pend=req_sel, clear timer, go DRAIN next cycle.
- Accepted request with req_sel==cur_sel: no-op, no pulse.
REQ-009 SHALL hold req_ready=0 in DRAIN and ALIGN, and SHALL ignore req_valid there.
REQ-010 DRAIN: switch stays cur_sel and drop=0.
- On frame_end: cur_sel<=pend, clear timer, go ALIGN; switch changes the cycle after the frame_end beat.
REQ-011 ALIGN: switch=cur_sel(new) and drop=(state==ALIGN)&&!(mon_tvalid&&mon_tuser), combinational on mon_tuser, so the SOF beat is passed and not dropped.
- On SOF handshake: go RUN, pulse switch_done the following cycle.
REQ-012 Timer:
- increments every cycle in DRAIN or ALIGN.
- reaching TIMEOUT in DRAIN forces the ALIGN transition.
- reaching TIMEOUT in ALIGN forces RUN with switch_done.
- either case sets timeout_err, which SHALL stay set until reset.
REQ-013 A frame_end and a timeout in the same cycle SHALL be treated as frame_end; timeout_err SHALL NOT be set.
REQ-014 busy SHALL be a registered copy of (state!=RUN), aligned with state.
REQ-015 SHALL have no combinational path from req_* to any output other than drop's dependence on mon_tvalid and mon_tuser.

Reset
REQ-016 With aresetn=0 at a clk edge, the block SHALL enter RUN with these values: cur_sel=0, pend=0, switch=0, line_cnt=0, timer=0, drop=0, busy=0, switch_done=0, timeout_err=0. req_ready SHALL be 1 from the first cycle after reset.
REQ-017 Reset asserted during DRAIN or ALIGN SHALL abort the switch and return switch to 0 at the same edge.

Verification (V_ACTIVE=4, TIMEOUT=64 unless noted)
REQ-018 Normal switch:
- Stimulus: req 0->2 mid-line 1, then 4 lines complete.
- Response: switch stays 0 through the 4th tlast, then becomes 2 the next cycle.
- Response: drop stays high until source 2's tuser beat, then switch_done pulses once.
REQ-019 Same-source request:
- Stimulus: req_sel=0 while cur_sel=0.
- Response: state stays RUN, busy=0, no switch_done.
REQ-020 Backpressure:
- Stimulus: mon_tready=0 on the final tlast beat for 5 cycles.
- Response: no transition until the handshake cycle, and no tlast beat is counted twice.
REQ-021 Drain timeout:
- Stimulus: no tlast after req 0->3.
- Response: at cycle 64, switch=3 and timeout_err=1.
- Response: timeout_err stays 1 after the later normal switch to 1.
REQ-022 Reset mid-ALIGN:
- Stimulus: aresetn=0 for 1 cycle while switch=2.
- Response: next cycle switch=0, drop=0, busy=0, req_ready=1.
REQ-023 Single-line frame:
- Stimulus: V_ACTIVE=1, tuser&&tlast on the same beat.
- Response: that beat is frame_end, and the switch completes.
